// File: rtl/combat_resolver_n.sv
// combat_resolver_n: frame-rate combat arbiter for 2..4 players.
// Checks every armed attacker hitbox against every opponent hurtbox, lets each
// attack instance land once per defender, applies damage/hitstun/knockback,
// and runs the IDLE -> FIGHT -> KO_HOLD round state machine.
module combat_resolver_n #(
  parameter int NUM_PLAYERS    = 2,
  parameter int POS_WIDTH      = 10,
  parameter int HP_WIDTH       = 8,
  parameter int HP_MAX         = 100,
  parameter int DMG_LIGHT      = 8,
  parameter int DMG_HEAVY      = 15,
  parameter int HITSTUN_LIGHT  = 12,
  parameter int HITSTUN_HEAVY  = 20,
  parameter int ACT1_START     = 2,
  parameter int ACT1_END       = 5,
  parameter int ACT2_START     = 4,
  parameter int ACT2_END       = 9,
  parameter int HURT_W         = 16,
  parameter int HURT_H         = 28,
  parameter int HURT_OFFX      = -8,
  parameter int HURT_OFFY      = -28,
  parameter int ATK1_W         = 18,
  parameter int ATK1_H         = 12,
  parameter int ATK1_FWD       = 14,
  parameter int ATK1_UP        = -16,
  parameter int ATK2_W         = 22,
  parameter int ATK2_H         = 14,
  parameter int ATK2_FWD       = 20,
  parameter int ATK2_UP        = -12,
  parameter int KB_LIGHT_X     = 3,
  parameter int KB_LIGHT_Y     = -2,
  parameter int KB_HEAVY_X     = 5,
  parameter int KB_HEAVY_Y     = -3,
  parameter int KO_HOLD_FRAMES = 90
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             SCEN,
  input  logic                             round_start,
  input  logic [NUM_PLAYERS*POS_WIDTH-1:0] p_x,
  input  logic [NUM_PLAYERS*POS_WIDTH-1:0] p_y,
  input  logic [NUM_PLAYERS-1:0]           p_face_right,
  input  logic [NUM_PLAYERS-1:0]           p_attack_active,
  input  logic [2*NUM_PLAYERS-1:0]         p_attack_type,
  input  logic [6*NUM_PLAYERS-1:0]         p_attack_frame,
  output logic [NUM_PLAYERS-1:0]           hit_event,
  output logic [NUM_PLAYERS-1:0]           hitstun_active,
  output logic [8*NUM_PLAYERS-1:0]         kb_dx,
  output logic [8*NUM_PLAYERS-1:0]         kb_dy,
  output logic [NUM_PLAYERS*HP_WIDTH-1:0]  hp,
  output logic [1:0]                       round_state,
  output logic                             ko_pulse,
  output logic [1:0]                       winner,
  output logic                             draw
);

  localparam int N  = NUM_PLAYERS;
  localparam int GW = POS_WIDTH + 8;
  localparam int SW = 8;
  localparam int KW = $clog2(KO_HOLD_FRAMES + 1);

  typedef logic signed [GW-1:0] geo_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIGHT = 2'd1, ST_KO = 2'd2} state_t;

  localparam geo_t HURT_W_G  = geo_t'(HURT_W);
  localparam geo_t HURT_H_G  = geo_t'(HURT_H);
  localparam geo_t HURT_OX_G = geo_t'(HURT_OFFX);
  localparam geo_t HURT_OY_G = geo_t'(HURT_OFFY);
  localparam logic [5:0] A1S = 6'(ACT1_START);
  localparam logic [5:0] A1E = 6'(ACT1_END);
  localparam logic [5:0] A2S = 6'(ACT2_START);
  localparam logic [5:0] A2E = 6'(ACT2_END);
  localparam logic signed [7:0] KBLX = 8'(KB_LIGHT_X);
  localparam logic signed [7:0] KBLY = 8'(KB_LIGHT_Y);
  localparam logic signed [7:0] KBHX = 8'(KB_HEAVY_X);
  localparam logic signed [7:0] KBHY = 8'(KB_HEAVY_Y);

  // HP never wraps below zero.
  function automatic logic [HP_WIDTH-1:0] sat_sub(input logic [HP_WIDTH-1:0] a,
                                                  input logic [HP_WIDTH-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  state_t                    state_q;
  logic [HP_WIDTH-1:0]       hp_q      [N];
  logic [SW-1:0]             stun_cnt_q[N];
  logic [N-1:0]              stun_q;
  logic signed [7:0]         kbx_q     [N];
  logic signed [7:0]         kby_q     [N];
  logic [N-1:0]              latch_q   [N];
  logic [N-1:0]              hit_q;
  logic                      ko_pulse_q;
  logic [1:0]                winner_q;
  logic                      draw_q;
  logic [KW-1:0]             ko_cnt_q;

  geo_t                      px_v[N], py_v[N], box_x[N], box_y[N], hurt_x[N], hurt_y[N];
  geo_t                      aw_v[N], ah_v[N];
  logic [N-1:0]              armed_v, heavy_v, hit_vec;
  int                        att_idx[N];
  logic [HP_WIDTH-1:0]       dmg_v[N], hp_d[N];
  logic signed [7:0]         kbx_v[N], kby_v[N];
  logic [N-1:0]              latch_d[N];
  logic [2:0]                alive_cnt;
  logic [1:0]                surv_idx;
  logic                      fight_scen;

  // Geometry, hit qualification on pre-update state, and post-hit HP.
  always_comb begin
    fight_scen = SCEN && (state_q == ST_FIGHT);
    alive_cnt  = '0;
    surv_idx   = '0;
    for (int i = 0; i < N; i++) begin
      px_v[i]    = $signed({8'b0, p_x[i*POS_WIDTH +: POS_WIDTH]});
      py_v[i]    = $signed({8'b0, p_y[i*POS_WIDTH +: POS_WIDTH]});
      heavy_v[i] = (p_attack_type[2*i +: 2] == 2'd2);
      aw_v[i]    = heavy_v[i] ? geo_t'(ATK2_W) : geo_t'(ATK1_W);
      ah_v[i]    = heavy_v[i] ? geo_t'(ATK2_H) : geo_t'(ATK1_H);
      box_x[i]   = p_face_right[i]
                   ? px_v[i] + (heavy_v[i] ? geo_t'(ATK2_FWD) : geo_t'(ATK1_FWD))
                   : px_v[i] - ((heavy_v[i] ? geo_t'(ATK2_FWD) : geo_t'(ATK1_FWD)) + aw_v[i]);
      box_y[i]   = py_v[i] + (heavy_v[i] ? geo_t'(ATK2_UP) : geo_t'(ATK1_UP));
      hurt_x[i]  = px_v[i] + HURT_OX_G;
      hurt_y[i]  = py_v[i] + HURT_OY_G;
      armed_v[i] = p_attack_active[i] && !stun_q[i] && (hp_q[i] != '0) &&
                   (((p_attack_type[2*i +: 2] == 2'd1) &&
                     (p_attack_frame[6*i +: 6] >= A1S) && (p_attack_frame[6*i +: 6] <= A1E)) ||
                    ((p_attack_type[2*i +: 2] == 2'd2) &&
                     (p_attack_frame[6*i +: 6] >= A2S) && (p_attack_frame[6*i +: 6] <= A2E)));
    end
    for (int j = 0; j < N; j++) begin
      hit_vec[j] = 1'b0;
      att_idx[j] = 0;
      dmg_v[j]   = '0;
      kbx_v[j]   = '0;
      kby_v[j]   = '0;
      // Descending scan so the lowest qualifying attacker is the one kept.
      for (int i = N - 1; i >= 0; i--) begin
        if (i != j && armed_v[i] && fight_scen && !stun_q[j] && (hp_q[j] != '0) &&
            !latch_q[i][j] &&
            (box_x[i] < hurt_x[j] + HURT_W_G) && (hurt_x[j] < box_x[i] + aw_v[i]) &&
            (box_y[i] < hurt_y[j] + HURT_H_G) && (hurt_y[j] < box_y[i] + ah_v[i])) begin
          hit_vec[j] = 1'b1;
          att_idx[j] = i;
          dmg_v[j]   = heavy_v[i] ? HP_WIDTH'(DMG_HEAVY) : HP_WIDTH'(DMG_LIGHT);
          kbx_v[j]   = p_face_right[i] ? (heavy_v[i] ? KBHX : KBLX)
                                       : -(heavy_v[i] ? KBHX : KBLX);
          kby_v[j]   = heavy_v[i] ? KBHY : KBLY;
        end
      end
      hp_d[j] = hit_vec[j] ? sat_sub(hp_q[j], dmg_v[j]) : hp_q[j];
      if (hp_d[j] != '0) begin
        alive_cnt = alive_cnt + 3'd1;
        surv_idx  = 2'(j);
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        latch_d[i][j] = p_attack_active[i] && (latch_q[i][j] || (hit_vec[j] && att_idx[j] == i));
      end
    end
  end

  // Round FSM plus per-player HP, hitstun, knockback and latch state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stun_q     <= '0;
      hit_q      <= '0;
      ko_pulse_q <= 1'b0;
      winner_q   <= '0;
      draw_q     <= 1'b0;
      ko_cnt_q   <= '0;
      for (int j = 0; j < N; j++) begin
        hp_q[j]       <= HP_WIDTH'(HP_MAX);
        stun_cnt_q[j] <= '0;
        kbx_q[j]      <= '0;
        kby_q[j]      <= '0;
        latch_q[j]    <= '0;
      end
    end else begin
      hit_q      <= '0;
      ko_pulse_q <= 1'b0;
      if (state_q == ST_IDLE && round_start) begin
        state_q  <= ST_FIGHT;
        stun_q   <= '0;
        winner_q <= '0;
        draw_q   <= 1'b0;
        ko_cnt_q <= '0;
        for (int j = 0; j < N; j++) begin
          hp_q[j]       <= HP_WIDTH'(HP_MAX);
          stun_cnt_q[j] <= '0;
          kbx_q[j]      <= '0;
          kby_q[j]      <= '0;
          latch_q[j]    <= '0;
        end
      end else if (SCEN) begin
        latch_q <= latch_d;
        for (int j = 0; j < N; j++) begin
          if (hit_vec[j]) begin
            hp_q[j]       <= hp_d[j];
            stun_q[j]     <= 1'b1;
            stun_cnt_q[j] <= heavy_v[att_idx[j]] ? SW'(HITSTUN_HEAVY - 1) : SW'(HITSTUN_LIGHT - 1);
            kbx_q[j]      <= kbx_v[j];
            kby_q[j]      <= kby_v[j];
            hit_q[j]      <= 1'b1;
          end else if (stun_q[j]) begin
            if (stun_cnt_q[j] == '0) begin
              stun_q[j] <= 1'b0;
              kbx_q[j]  <= '0;
              kby_q[j]  <= '0;
            end else begin
              stun_cnt_q[j] <= stun_cnt_q[j] - 1'b1;
            end
          end
        end
        case (state_q)
          ST_FIGHT: begin
            if (alive_cnt <= 3'd1) begin
              state_q    <= ST_KO;
              ko_pulse_q <= 1'b1;
              ko_cnt_q   <= '0;
              winner_q   <= (alive_cnt == 3'd1) ? surv_idx : 2'd0;
              draw_q     <= (alive_cnt == 3'd0);
            end
          end
          ST_KO: begin
            if (ko_cnt_q == KW'(KO_HOLD_FRAMES - 1)) state_q <= ST_IDLE;
            else ko_cnt_q <= ko_cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_out
      assign hp[g*HP_WIDTH +: HP_WIDTH] = hp_q[g];
      assign kb_dx[8*g +: 8]            = kbx_q[g];
      assign kb_dy[8*g +: 8]            = kby_q[g];
    end
  endgenerate

  assign hit_event      = hit_q;
  assign hitstun_active = stun_q;
  assign round_state    = state_q;
  assign ko_pulse       = ko_pulse_q;
  assign winner         = winner_q;
  assign draw           = draw_q;

endmodule
